universal_shift_register: RTL

UNIVERSAL_SHIFT_REGISTER -- requirements
Module: universal_shift_register

---
 rtl/usr_pkg.sv | 16 +
 rtl/usr_count_sat.sv | 41 ++++
 rtl/universal_shift_register.sv | 82 ++++++++
 3 files changed

// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: operating mode encodings
// and counter width helper.
package usr_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'b00,
    SHR  = 2'b01,
    SHL  = 2'b10,
    LOAD = 2'b11
  } usr_mode_e;

  function automatic int usr_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/usr_count_sat.sv
// Saturating shift counter: counts shifts since the last load, sticking at WIDTH,
// and flags "drained" when the whole register contents have been shifted out.
module usr_count_sat
  import usr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = usr_cnt_w(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o,
  output logic             drained_o
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(WIDTH);

  logic [CNT_W-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != CntMax)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o   = count_q;
  assign drained_o = (count_q == CntMax);

endmodule

// File: rtl/universal_shift_register.sv
// Universal shift register: hold, shift right/left with serial fill, parallel load.
// Define USR_ROTATE_EN to add input_rotate, which recirculates the outgoing bit.
module universal_shift_register
  import usr_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                         input_clock,
  input  logic                         input_reset_n,
  input  logic                         input_enable,
  input  logic [1:0]                   input_mode,
  input  logic                         input_serial_msb,
  input  logic                         input_serial_lsb,
`ifdef USR_ROTATE_EN
  input  logic                         input_rotate,
`endif
  input  logic [WIDTH-1:0]             input_data,
  output logic [WIDTH-1:0]             output_q,
  output logic                         output_shift_out,
  output logic [usr_cnt_w(WIDTH)-1:0]  output_count,
  output logic                         output_drained
);

  usr_mode_e        mode;
  logic [WIDTH-1:0] q_q;
  logic             shift_out_q;
  logic             msb_in, lsb_in;
  logic             shift_en, load_en;

  assign mode = usr_mode_e'(input_mode);

`ifdef USR_ROTATE_EN
  // Rotating feeds each end with the bit leaving the opposite end.
  assign msb_in = input_rotate ? q_q[0]       : input_serial_msb;
  assign lsb_in = input_rotate ? q_q[WIDTH-1] : input_serial_lsb;
`else
  assign msb_in = input_serial_msb;
  assign lsb_in = input_serial_lsb;
`endif

  assign shift_en = input_enable && ((mode == SHR) || (mode == SHL));
  assign load_en  = input_enable && (mode == LOAD);

  always_ff @(posedge input_clock or negedge input_reset_n) begin
    if (!input_reset_n) begin
      q_q         <= RESET_VALUE;
      shift_out_q <= 1'b0;
    end else if (input_enable) begin
      case (mode)
        SHR: begin
          q_q         <= {msb_in, q_q[WIDTH-1:1]};
          shift_out_q <= q_q[0];
        end
        SHL: begin
          q_q         <= {q_q[WIDTH-2:0], lsb_in};
          shift_out_q <= q_q[WIDTH-1];
        end
        LOAD: begin
          q_q         <= input_data;
          shift_out_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  usr_count_sat #(
    .WIDTH(WIDTH)
  ) u_count (
    .clk_i     (input_clock),
    .rst_n_i   (input_reset_n),
    .clr_i     (load_en),
    .inc_i     (shift_en),
    .count_o   (output_count),
    .drained_o (output_drained)
  );

  assign output_q         = q_q;
  assign output_shift_out = shift_out_q;

endmodule
